// File: rtl/special_reg_pkg.sv
// Shared constants and helpers for the LO/HI/STATUS special-register bank.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
// STATUS bit positions are fixed. The context-frame struct is declared inside
// special_reg_bank because its field widths follow that module's DATA_W.
package special_reg_pkg;

    localparam int unsigned STATUS_OVF_BIT   = 0;
    localparam int unsigned STATUS_CARRY_BIT = 1;
    localparam int unsigned STATUS_NEG_BIT   = 2;
    localparam int unsigned STATUS_ZERO_BIT  = 3;
    localparam int unsigned STATUS_FLAG_W    = 4;

    // Packs the four ALU flags into the STATUS flag nibble.
    function automatic logic [STATUS_FLAG_W-1:0] status_flags(
        input logic ovf,
        input logic carry,
        input logic neg,
        input logic zero
    );
        logic [STATUS_FLAG_W-1:0] f;
        f                   = '0;
        f[STATUS_OVF_BIT]   = ovf;
        f[STATUS_CARRY_BIT] = carry;
        f[STATUS_NEG_BIT]   = neg;
        f[STATUS_ZERO_BIT]  = zero;
        return f;
    endfunction

endpackage

// File: rtl/ctx_lifo.sv
// Generic LIFO of WIDTH-bit frames, DEPTH entries deep, with an occupancy count.
// Latency: a push or pop updates the count one cycle later. o_top_dat is a combinational read of the top frame.
// Backpressure: an illegal request pulses o_err for one cycle. Illegal requests are a push while full, a pop while empty, or a push and a pop in the same cycle.
// Ports: clock/reset (async, active-high), i_push/i_pop requests, i_push_dat
// write frame, o_top_dat top frame, o_pop_ok legal pop this cycle,
// o_full/o_empty/o_count occupancy, o_err registered error pulse.
module ctx_lifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_push_dat,
    output logic [WIDTH-1:0] o_top_dat,
    output logic             o_pop_ok,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count,
    output logic             o_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    logic             w_full;
    logic             w_empty;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_err;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_top_idx;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    // A simultaneous push and pop cancel each other and count as an error.
    assign w_push_ok = i_push & ~i_pop & ~w_full;
    assign w_pop_ok  = i_pop & ~i_push & ~w_empty;
    assign w_err     = (i_push & i_pop) | (i_push & w_full) | (i_pop & w_empty);
    assign w_wr_idx  = IDX_W'(r_count);
    assign w_top_idx = IDX_W'(r_count - 1'b1);

    // Frame storage needs no reset: only entries below r_count are ever read.
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[w_wr_idx] <= i_push_dat;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_err;
            if (w_push_ok) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_top_dat = r_mem[w_top_idx];
    assign o_pop_ok  = w_pop_ok;
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_count   = r_count;
    assign o_err     = r_err;

endmodule

// File: rtl/special_reg_bank.sv
// LO/HI/STATUS special registers with a LIFO that saves and restores context on interrupt entry and exit.
// Latency: every update is visible one cycle after the triggering edge. All outputs are registered.
// Backpressure: none. An illegal push or pop is dropped and pulses stack_err for one cycle.
// Ports: clock/reset (async, active-high); write_lo/value_lo, write_hi/value_hi
// register writes; flag_update + overflow/carry/negative/zero ALU flags;
// status_write/status_value software STATUS write; ctx_push/ctx_pop context
// save/restore; data_lo/data_hi/data_status register outputs;
// stack_count/stack_full/stack_empty/stack_err stack state.
// Build option: define SPECIAL_REG_STICKY_FLAGS_EN to make flag_update OR the
// flags into STATUS (sticky). Without it, flag_update replaces them.
module special_reg_bank
    import special_reg_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write_lo,
    input  logic              write_hi,
    input  logic [DATA_W-1:0] value_lo,
    input  logic [DATA_W-1:0] value_hi,
    input  logic              flag_update,
    input  logic              overflow,
    input  logic              carry,
    input  logic              negative,
    input  logic              zero,
    input  logic              status_write,
    input  logic [DATA_W-1:0] status_value,
    input  logic              ctx_push,
    input  logic              ctx_pop,
    output logic [DATA_W-1:0] data_lo,
    output logic [DATA_W-1:0] data_hi,
    output logic [DATA_W-1:0] data_status,
    output logic [CNT_W-1:0]  stack_count,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    typedef struct packed {
        logic [DATA_W-1:0] lo;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] status;
    } ctx_frame_t;

    localparam int unsigned FRAME_W = $bits(ctx_frame_t);

    logic [DATA_W-1:0]        r_lo;
    logic [DATA_W-1:0]        r_hi;
    // Only the flag nibble is stored. The upper STATUS bits are constant zero.
    logic [STATUS_FLAG_W-1:0] r_status;

    ctx_frame_t               w_push_frame;
    ctx_frame_t               w_pop_frame;
    logic [FRAME_W-1:0]       w_top_dat;
    logic                     w_pop_ok;
    logic [STATUS_FLAG_W-1:0] w_alu_flags;

    assign w_push_frame = '{lo: r_lo, hi: r_hi, status: DATA_W'(r_status)};
    assign w_pop_frame  = ctx_frame_t'(w_top_dat);
    assign w_alu_flags  = status_flags(overflow, carry, negative, zero);

    ctx_lifo #(
        .WIDTH (FRAME_W),
        .DEPTH (STACK_DEPTH),
        .CNT_W (CNT_W)
    ) u_ctx_lifo (
        .clock      (clock),
        .reset      (reset),
        .i_push     (ctx_push),
        .i_pop      (ctx_pop),
        .i_push_dat (w_push_frame),
        .o_top_dat  (w_top_dat),
        .o_pop_ok   (w_pop_ok),
        .o_full     (stack_full),
        .o_empty    (stack_empty),
        .o_count    (stack_count),
        .o_err      (stack_err)
    );

    // A legal pop overrides every other write in that cycle. An illegal pop
    // falls through, so the ordinary writes still apply.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lo     <= '0;
            r_hi     <= '0;
            r_status <= '0;
        end else if (w_pop_ok) begin
            r_lo     <= w_pop_frame.lo;
            r_hi     <= w_pop_frame.hi;
            r_status <= w_pop_frame.status[STATUS_FLAG_W-1:0];
        end else begin
            if (write_lo) begin
                r_lo <= value_lo;
            end
            if (write_hi) begin
                r_hi <= value_hi;
            end
            if (status_write) begin
                r_status <= status_value[STATUS_FLAG_W-1:0];
            end else if (flag_update) begin
`ifdef SPECIAL_REG_STICKY_FLAGS_EN
                r_status <= r_status | w_alu_flags;
`else
                r_status <= w_alu_flags;
`endif
            end
        end
    end

    // The upper STATUS bits of software writes and popped frames are discarded.
    if (DATA_W > STATUS_FLAG_W) begin : g_status_hi
        logic w_unused_status_hi;
        assign w_unused_status_hi = ^{status_value[DATA_W-1:STATUS_FLAG_W],
                                      w_pop_frame.status[DATA_W-1:STATUS_FLAG_W]};
    end

    assign data_lo     = r_lo;
    assign data_hi     = r_hi;
    assign data_status = DATA_W'(r_status);

endmodule

// File: tb/tb_special_reg_bank.sv
module tb_special_reg_bank;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned STACK_DEPTH = 4;
    localparam int unsigned CNT_W       = $clog2(STACK_DEPTH + 1);

    logic              clock;
    logic              reset;
    logic              write_lo;
    logic              write_hi;
    logic [DATA_W-1:0] value_lo;
    logic [DATA_W-1:0] value_hi;
    logic              flag_update;
    logic              overflow;
    logic              carry;
    logic              negative;
    logic              zero;
    logic              status_write;
    logic [DATA_W-1:0] status_value;
    logic              ctx_push;
    logic              ctx_pop;
    logic [DATA_W-1:0] data_lo;
    logic [DATA_W-1:0] data_hi;
    logic [DATA_W-1:0] data_status;
    logic [CNT_W-1:0]  stack_count;
    logic              stack_full;
    logic              stack_empty;
    logic              stack_err;

    int n_assert;
    int n_fail;

    special_reg_bank #(
        .DATA_W      (DATA_W),
        .STACK_DEPTH (STACK_DEPTH),
        .CNT_W       (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .write_lo     (write_lo),
        .write_hi     (write_hi),
        .value_lo     (value_lo),
        .value_hi     (value_hi),
        .flag_update  (flag_update),
        .overflow     (overflow),
        .carry        (carry),
        .negative     (negative),
        .zero         (zero),
        .status_write (status_write),
        .status_value (status_value),
        .ctx_push     (ctx_push),
        .ctx_pop      (ctx_pop),
        .data_lo      (data_lo),
        .data_hi      (data_hi),
        .data_status  (data_status),
        .stack_count  (stack_count),
        .stack_full   (stack_full),
        .stack_empty  (stack_empty),
        .stack_err    (stack_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        write_lo     = 1'b0;
        write_hi     = 1'b0;
        value_lo     = '0;
        value_hi     = '0;
        flag_update  = 1'b0;
        overflow     = 1'b0;
        carry        = 1'b0;
        negative     = 1'b0;
        zero         = 1'b0;
        status_write = 1'b0;
        status_value = '0;
        ctx_push     = 1'b0;
        ctx_pop      = 1'b0;
    endtask

    // Clock the current inputs in, then sample 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        idle();
        reset = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_lo", data_lo, 32'h0);
        chk("rst_hi", data_hi, 32'h0);
        chk("rst_status", data_status, 32'h0);
        chk("rst_count", stack_count, 32'h0);
        chk("rst_empty", stack_empty, 32'h1);
        chk("rst_full", stack_full, 32'h0);
        chk("rst_err", stack_err, 32'h0);
        reset = 1'b0;
        step();

        // Test 1: load LO and push, then reset asynchronously mid-cycle.
        write_lo = 1'b1; value_lo = 16'h1234; ctx_push = 1'b1;
        step();
        idle();
        chk("t1_lo_loaded", data_lo, 32'h1234);
        chk("t1_count_1", stack_count, 32'h1);
        #3 reset = 1'b1;
        #1;
        chk("t1_async_lo", data_lo, 32'h0);
        chk("t1_async_count", stack_count, 32'h0);
        chk("t1_async_empty", stack_empty, 32'h1);
        #1 reset = 1'b0;
        step();

        // Test 2: replace the flags, then update them again.
        flag_update = 1'b1; carry = 1'b1; zero = 1'b1;
        step();
        idle();
        chk("t2_flags_a", data_status, 32'h000A);
        flag_update = 1'b1; negative = 1'b1;
        step();
        idle();
`ifdef SPECIAL_REG_STICKY_FLAGS_EN
        chk("t2_flags_b", data_status, 32'h000E);
`else
        chk("t2_flags_b", data_status, 32'h0004);
`endif

        // Test 3: push a context frame, modify the registers, then pop.
        write_lo = 1'b1; value_lo = 16'hAAAA;
        write_hi = 1'b1; value_hi = 16'h5555;
        status_write = 1'b1; status_value = 16'h0001;
        step();
        idle();
        chk("t3_status_1", data_status, 32'h0001);
        ctx_push = 1'b1;
        step();
        idle();
        chk("t3_push_count", stack_count, 32'h1);
        chk("t3_push_empty", stack_empty, 32'h0);
        write_lo = 1'b1; value_lo = 16'h1111;
        status_write = 1'b1; status_value = 16'h0008;
        step();
        idle();
        chk("t3_mod_lo", data_lo, 32'h1111);
        chk("t3_mod_status", data_status, 32'h0008);
        // The pop wins over a same-cycle LO write.
        ctx_pop = 1'b1; write_lo = 1'b1; value_lo = 16'h2222;
        step();
        idle();
        chk("t3_pop_lo", data_lo, 32'hAAAA);
        chk("t3_pop_hi", data_hi, 32'h5555);
        chk("t3_pop_status", data_status, 32'h0001);
        chk("t3_pop_count", stack_count, 32'h0);
        chk("t3_pop_err", stack_err, 32'h0);

        // Test 4: fill the stack, overflow it, drain it, and underflow it.
        // Each push saves the pre-edge LO and also writes a new LO.
        for (int i = 1; i <= 5; i++) begin
            ctx_push = 1'b1; write_lo = 1'b1; value_lo = 16'h0100 + 16'(i);
            step();
            idle();
            chk("t4_push_count", stack_count, (i <= 4) ? i : 4);
            chk("t4_push_full", stack_full, (i >= 4) ? 1 : 0);
            chk("t4_push_err", stack_err, (i == 5) ? 1 : 0);
        end
        chk("t4_ovf_lo", data_lo, 32'h0105);
        step();
        chk("t4_err_pulse", stack_err, 32'h0);
        // Expected LO after pops 1 to 4: 0103, 0102, 0101, AAAA.
        ctx_pop = 1'b1;
        step();
        chk("t4_pop1_lo", data_lo, 32'h0103);
        chk("t4_pop1_full", stack_full, 32'h0);
        step();
        chk("t4_pop2_lo", data_lo, 32'h0102);
        step();
        chk("t4_pop3_lo", data_lo, 32'h0101);
        step();
        idle();
        chk("t4_pop4_lo", data_lo, 32'hAAAA);
        chk("t4_pop4_status", data_status, 32'h0001);
        chk("t4_pop4_empty", stack_empty, 32'h1);
        ctx_pop = 1'b1; write_hi = 1'b1; value_hi = 16'h7777;
        step();
        idle();
        chk("t4_unf_err", stack_err, 32'h1);
        chk("t4_unf_count", stack_count, 32'h0);
        chk("t4_unf_hi", data_hi, 32'h7777);

        // Test 5: a simultaneous push and pop is rejected, but the LO write still applies.
        ctx_push = 1'b1;
        step();
        idle();
        chk("t5_pre_count", stack_count, 32'h1);
        ctx_push = 1'b1; ctx_pop = 1'b1; write_lo = 1'b1; value_lo = 16'h00FF;
        step();
        idle();
        chk("t5_err", stack_err, 32'h1);
        chk("t5_count", stack_count, 32'h1);
        chk("t5_lo", data_lo, 32'h00FF);
        ctx_pop = 1'b1;
        step();
        idle();
        chk("t5_restore_lo", data_lo, 32'hAAAA);
        chk("t5_restore_hi", data_hi, 32'h7777);

        // Test 6: a software STATUS write wins over flag_update. Upper bits read as 0.
        status_write = 1'b1; status_value = 16'hFFFF; flag_update = 1'b1;
        step();
        idle();
        chk("t6_status", data_status, 32'h000F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
